// File: rtl/iob_cache_axi_line_fill.sv
// AXI4 read-channel line-fill engine: one burst per cache line, each beat streamed back with its in-line index.
// Optional feature: define IOB_CACHE_AXI_CWF_EN for critical-word-first WRAP bursts.
module iob_cache_axi_line_fill #(
    parameter int BE_ADDR_W = 32,
    parameter int BE_DATA_W = 32,
    parameter int LINE2BE_W = 2,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_ID    = 0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           replace_valid,
    input  logic [BE_ADDR_W-$clog2(BE_DATA_W/8)-1:0]       replace_addr,
    output logic                                           replace,
    output logic                                           read_valid,
    output logic [((LINE2BE_W > 0) ? LINE2BE_W : 1)-1:0]   read_addr,
    output logic [BE_DATA_W-1:0]                           read_rdata,
    output logic                                           error,
    output logic                                           axi_arvalid,
    output logic [BE_ADDR_W-1:0]                           axi_araddr,
    output logic [7:0]                                     axi_arlen,
    output logic [2:0]                                     axi_arsize,
    output logic [1:0]                                     axi_arburst,
    output logic                                           axi_arlock,
    output logic [3:0]                                     axi_arcache,
    output logic [2:0]                                     axi_arprot,
    output logic [3:0]                                     axi_arqos,
    output logic [AXI_ID_W-1:0]                            axi_arid,
    input  logic                                           axi_arready,
    input  logic                                           axi_rvalid,
    input  logic [BE_DATA_W-1:0]                           axi_rdata,
    input  logic [1:0]                                     axi_rresp,
    input  logic                                           axi_rlast,
    output logic                                           axi_rready
);

    localparam int NB     = $clog2(BE_DATA_W/8);
    localparam int AW     = BE_ADDR_W - NB;
    localparam int LA_W   = (LINE2BE_W > 0) ? LINE2BE_W : 1;
    localparam int NBEATS = 1 << LINE2BE_W;
    localparam logic [AW-1:0]        LINE_MASK = AW'(NBEATS - 1);
    localparam logic [LINE2BE_W:0]   LAST_CNT  = (LINE2BE_W+1)'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                 r_state, w_next;
    logic [LA_W-1:0]        r_idx, r_read_addr, w_start;
    logic [LINE2BE_W:0]     r_cnt;
    logic [AW-1:0]          w_req_beat;
    logic [BE_ADDR_W-1:0]   r_araddr;
    logic [BE_DATA_W-1:0]   r_rdata;
    logic                   r_read_valid, r_error;
    logic                   w_rhs, w_final;
    logic [1:0]             w_burst;
    logic                   w_unused_rresp;

`ifdef IOB_CACHE_AXI_CWF_EN
    assign w_req_beat = replace_addr;
    assign w_start    = (LINE2BE_W > 0) ? replace_addr[LA_W-1:0] : '0;
    assign w_burst    = (LINE2BE_W > 0) ? 2'b10 : 2'b01;
`else
    assign w_req_beat = replace_addr & ~LINE_MASK;
    assign w_start    = '0;
    assign w_burst    = 2'b01;
`endif

    assign w_rhs          = (r_state == DATA) && axi_rvalid;
    assign w_final        = (r_cnt == LAST_CNT);
    assign w_unused_rresp = axi_rresp[0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // An early rlast and the final beat both end the fill; DATA never outlives the line.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (replace_valid) w_next = ADDR;
            ADDR:    if (axi_arready) w_next = DATA;
            DATA:    if (w_rhs && (axi_rlast || w_final)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_araddr     <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_read_addr  <= '0;
            r_rdata      <= '0;
            r_read_valid <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_read_valid <= w_rhs;
            if ((r_state == IDLE) && replace_valid) begin
                r_araddr <= BE_ADDR_W'(w_req_beat) << NB;
                r_idx    <= w_start;
                r_cnt    <= '0;
                r_error  <= 1'b0;
            end
            if (w_rhs) begin
                r_rdata     <= axi_rdata;
                r_read_addr <= r_idx;
                r_idx       <= (LINE2BE_W > 0) ? r_idx + 1'b1 : '0;
                r_cnt       <= r_cnt + 1'b1;
                // rlast must coincide exactly with the final beat
                if (axi_rresp[1] || (axi_rlast != w_final)) r_error <= 1'b1;
            end
        end
    end

    assign replace     = (r_state != IDLE);
    assign read_valid  = r_read_valid;
    assign read_addr   = r_read_addr;
    assign read_rdata  = r_rdata;
    assign error       = r_error;
    assign axi_arvalid = (r_state == ADDR);
    assign axi_araddr  = r_araddr;
    assign axi_arlen   = 8'(NBEATS - 1);
    assign axi_arsize  = 3'(NB);
    assign axi_arburst = w_burst;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = 4'b0011;
    assign axi_arprot  = 3'b000;
    assign axi_arqos   = 4'b0000;
    assign axi_arid    = AXI_ID_W'(AXI_ID);
    assign axi_rready  = (r_state == DATA);

endmodule

// File: tb/tb_iob_cache_axi_line_fill.sv
// Randomized self-checking bench for iob_cache_axi_line_fill with a behavioural line-fill model and AXI slave.
// Follows IOB_CACHE_AXI_CWF_EN the same way as the design.
module tb_iob_cache_axi_line_fill;

    localparam int N = 4;
`ifdef IOB_CACHE_AXI_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct { logic [1:0] idx; logic [31:0] data; } beat_t;

    logic        clk, rst, replace_valid;
    logic [29:0] replace_addr;
    logic        replace, read_valid, error;
    logic [1:0]  read_addr;
    logic [31:0] read_rdata;
    logic        axi_arvalid, axi_arlock, axi_arready, axi_rvalid, axi_rlast, axi_rready;
    logic [31:0] axi_araddr, axi_rdata;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize, axi_arprot;
    logic [1:0]  axi_arburst, axi_rresp;
    logic [3:0]  axi_arcache, axi_arqos;
    logic [0:0]  axi_arid;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int beatK   = 0;
    int rvCount = 0;
    logic [29:0] curReq = '0;
    bit          pend = 0;
    beat_t       expQ[$];
    logic [1:0]  rdLog[$];
    logic [31:0] dataLog[$];
    logic [31:0] lastAraddr;
    logic [7:0]  lastArlen;
    logic [2:0]  lastArsize;
    logic [1:0]  lastArburst;

    iob_cache_axi_line_fill #(
        .BE_ADDR_W(32), .BE_DATA_W(32), .LINE2BE_W(2), .AXI_ID_W(1), .AXI_ID(0)
    ) dut (
        .clk(clk), .rst(rst),
        .replace_valid(replace_valid), .replace_addr(replace_addr),
        .replace(replace), .read_valid(read_valid), .read_addr(read_addr),
        .read_rdata(read_rdata), .error(error),
        .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
        .axi_arid(axi_arid), .axi_arready(axi_arready),
        .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rready(axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave memory contents: a fixed scramble of the byte address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    // Model: beat k of a fill lands at index (start+k) mod N of the requested line.
    function automatic beat_t modelBeat(input logic [29:0] req, input int k);
        beat_t b;
        int unsigned start, idx;
        logic [31:0] base;
        start  = CWF ? (int'(req) % N) : 0;
        idx    = (start + k) % N;
        base   = {2'b00, req} - ({2'b00, req} % N);
        b.idx  = 2'(idx);
        b.data = memWord((base + idx) * 4);
        return b;
    endfunction

    function automatic logic [31:0] expAraddr(input logic [29:0] req);
        logic [31:0] byteAddr;
        byteAddr = {req, 2'b00};
        return CWF ? byteAddr : byteAddr - (byteAddr % (4 * N));
    endfunction

    // AXI slave address generation for INCR and WRAP bursts.
    function automatic logic [31:0] slaveAddr(input logic [31:0] a, input logic [1:0] burst, input int k);
        logic [31:0] bound;
        if (burst == 2'b10) begin
            bound = a & ~32'(4 * N - 1);
            return bound + ((a - bound + 32'(4 * k)) % (4 * N));
        end
        return a + 32'(4 * k);
    endfunction

    // Compare process: read_valid must follow each R handshake by one cycle with the modelled beat.
    always @(negedge clk) begin
        beat_t e;
        checkOutput("read_valid", read_valid, pend);
        if (pend && expQ.size() > 0) begin
            e = expQ.pop_front();
            if (read_valid) begin
                checkOutput("read_addr", read_addr, e.idx);
                checkOutput("read_rdata", read_rdata, e.data);
                rvCount++;
                rdLog.push_back(read_addr);
                dataLog.push_back(read_rdata);
            end
        end
        #4;
        if (rst) begin
            pend = 0;
            expQ.delete();
        end else begin
            pend = axi_rvalid && axi_rready;
            if (pend) begin
                expQ.push_back(modelBeat(curReq, beatK));
                beatK++;
            end
        end
    end

    task automatic applyStimulus(input logic [29:0] req, input int arDelay, input int gapMax,
                                 input int badBeat, input int lastBeat, input int abortBeat,
                                 input bit pinLatency);
        int nb, cycReq;
        bit expErr, ok;
        logic [31:0] cap;
        logic [1:0]  capBurst, expBurst;
        nb       = (lastBeat < N) ? lastBeat + 1 : N;
        expErr   = ((badBeat >= 0) && (badBeat < nb)) || (lastBeat != N - 1);
        expBurst = CWF ? 2'b10 : 2'b01;
        cycReq   = cyc;
        curReq   = req;
        beatK    = 0;
        rvCount  = 0;
        cap      = '0;
        capBurst = '0;
        rdLog.delete();
        dataLog.delete();
        replace_valid = 1'b1;
        replace_addr  = req;
        @(negedge clk);
        replace_valid = 1'b0;
        replace_addr  = 30'($urandom);
        checkOutput("replace_after_accept", replace, 1);
        checkOutput("error_cleared", error, 0);
        for (int d = 0; d <= arDelay; d++) begin
            checkOutput("arvalid", axi_arvalid, 1);
            checkOutput("araddr", axi_araddr, expAraddr(req));
            checkOutput("arlen", axi_arlen, N - 1);
            checkOutput("arsize", axi_arsize, 2);
            checkOutput("arburst", axi_arburst, expBurst);
            checkOutput("ar_misc", {axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arid},
                        {1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0});
            checkOutput("rready_in_addr", axi_rready, 0);
            if (d == arDelay) begin
                cap         = axi_araddr;
                capBurst    = axi_arburst;
                lastAraddr  = axi_araddr;
                lastArlen   = axi_arlen;
                lastArsize  = axi_arsize;
                lastArburst = axi_arburst;
                axi_arready = 1'b1;
            end
            @(negedge clk);
        end
        axi_arready = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (k == abortBeat) begin
                rst = 1'b1;
                axi_rvalid = 1'b0;
                replace_valid = 1'b0;
                @(negedge clk);
                checkOutput("abort_replace", replace, 0);
                checkOutput("abort_arvalid", axi_arvalid, 0);
                checkOutput("abort_rready", axi_rready, 0);
                checkOutput("abort_read_valid", read_valid, 0);
                checkOutput("abort_error", error, 0);
                checkOutput("abort_read_addr", read_addr, 0);
                checkOutput("abort_read_rdata", read_rdata, 0);
                checkOutput("abort_araddr", axi_araddr, 0);
                rst = 1'b0;
                return;
            end
            repeat ($urandom_range(0, gapMax)) begin
                axi_rvalid = 1'b0;
                replace_valid = 1'($urandom);
                @(negedge clk);
            end
            axi_rvalid = 1'b1;
            axi_rdata  = memWord(slaveAddr(cap, capBurst, k));
            axi_rresp  = (k == badBeat) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
            axi_rlast  = (k == lastBeat);
            ok = 0;
            for (int t = 0; t < 20 && !ok; t++) begin
                #4;
                ok = axi_rready;
                @(negedge clk);
            end
            if (!ok) begin
                checkOutput("r_handshake_timeout", 0, 1);
                axi_rvalid = 1'b0;
                replace_valid = 1'b0;
                return;
            end
        end
        axi_rvalid    = (lastBeat >= N);
        axi_rlast     = 1'b0;
        axi_rresp     = 2'b00;
        replace_valid = 1'b0;
        checkOutput("replace_in_done", replace, 1);
        checkOutput("rready_in_done", axi_rready, 0);
        @(negedge clk);
        axi_rvalid = 1'b0;
        checkOutput("replace_idle", replace, 0);
        checkOutput("error_after_fill", error, expErr);
        checkOutput("beat_count", rvCount, nb);
        if (pinLatency) checkOutput("fill_latency", cyc - cycReq + 1, N + 4);
    endtask

    initial begin
        logic [1:0]  seq[4];
        logic [31:0] pinAddr, pinBurst, firstAddr;
        rst = 1'b1;
        replace_valid = 1'b0;
        replace_addr = '0;
        axi_arready = 1'b0;
        axi_rvalid = 1'b0;
        axi_rdata = '0;
        axi_rresp = '0;
        axi_rlast = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_replace", replace, 0);
        checkOutput("reset_arvalid", axi_arvalid, 0);
        checkOutput("reset_rready", axi_rready, 0);
        checkOutput("reset_read_valid", read_valid, 0);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_read_addr", read_addr, 0);
        checkOutput("reset_read_rdata", read_rdata, 0);
        checkOutput("reset_araddr", axi_araddr, 0);
        rst = 1'b0;

        // Beat address 0x048D: line base beat 0x048C, in-line index 1.
        applyStimulus(30'h048D, 0, 0, -1, N - 1, -1, 1);
`ifdef IOB_CACHE_AXI_CWF_EN
        pinAddr = 32'h1234; pinBurst = 32'd2; firstAddr = 32'h1234;
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
`else
        pinAddr = 32'h1230; pinBurst = 32'd1; firstAddr = 32'h1230;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3;
`endif
        checkOutput("pin_araddr", lastAraddr, pinAddr);
        checkOutput("pin_arburst", lastArburst, pinBurst);
        checkOutput("pin_arlen", lastArlen, 3);
        checkOutput("pin_arsize", lastArsize, 2);
        checkOutput("pin_seq_len", rdLog.size(), 4);
        for (int i = 0; i < 4 && i < rdLog.size(); i++) checkOutput("pin_read_addr_seq", rdLog[i], seq[i]);
        if (dataLog.size() > 0) checkOutput("pin_first_word", dataLog[0], memWord(firstAddr));

        applyStimulus(30'($urandom), 5, 3, -1, N - 1, -1, 0);
        applyStimulus(30'($urandom), 0, 1, 2, N - 1, -1, 0);
        applyStimulus(30'($urandom), 0, 0, -1, N - 1, -1, 1);
        applyStimulus(30'($urandom), 0, 2, -1, 1, -1, 0);
        applyStimulus(30'($urandom), 0, 2, -1, N, -1, 0);
        applyStimulus(30'($urandom), 2, 1, -1, N - 1, 1, 0);
        applyStimulus(30'($urandom), 0, 0, -1, N - 1, -1, 1);
        for (int r = 0; r < 12; r++) begin
            applyStimulus(30'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                          N - 1, -1, 0);
        end
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
